// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants, types and helpers for the data_memory block.
package data_memory_pkg;

  // Default geometry: 32-bit words, 5-bit word address (32 words).
  localparam int DM_W = 32;
  localparam int DM_N = 5;

  typedef logic [DM_W-1:0] dm_word_t;
  typedef logic [DM_N-1:0] dm_addr_t;

  // Number of words addressed by an n-bit word address.
  function automatic int dm_depth(input int n);
    return 1 << n;
  endfunction

endpackage : data_memory_pkg

// File: rtl/data_memory_if.sv
// data_memory_if: memory-stage port of the data RAM.
//
// Transfer semantics: there is no valid/ready pair. The RAM is always ready.
// A write is accepted at every rising clock edge where we=1. read_data is
// valid every cycle. In the default build it follows address in the same
// cycle. In the registered build it shows the word addressed at the
// previous rising edge.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int W = DM_W,
  parameter int N = DM_N
);

  logic [N-1:0] address;
  logic         we;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;

  // Processor side: drives the address and write controls, receives read data.
  modport master (
    output address,
    output we,
    output write_data,
    input  read_data
  );

  // RAM side.
  modport slave (
    input  address,
    input  we,
    input  write_data,
    output read_data
  );

endinterface : data_memory_if

// File: rtl/data_memory_rd_reg.sv
// data_memory_rd_reg: W-bit read-data output register with asynchronous
// active-low reset to zero. It is used only when the registered-output read
// path is built.
module data_memory_rd_reg
  import data_memory_pkg::*;
#(
  parameter int W = DM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture the combinational read word each rising edge; clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : data_memory_rd_reg

// File: rtl/data_memory.sv
// data_memory: single-port, word-addressed data RAM for the memory stage.
// The depth is 2**N words of W bits. Writes are synchronous. An asynchronous
// active-low reset clears every word.
// Optional build macro DATA_MEMORY_REG_OUT_EN registers read_data, which gives
// one cycle of read latency and read-first behaviour on a same-address write.
// Without the macro the read is combinational.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int W = DM_W,
  parameter int N = DM_N
) (
  input  logic           clk,
  input  logic           rst_n,
  data_memory_if.slave   bus
);

  localparam int DEPTH = dm_depth(N);

  // Storage: the word index is the address itself, with no offset or wrap.
  logic [W-1:0] r_mem [DEPTH];

  // The word currently addressed, before any output register.
  logic [W-1:0] w_rd_word;

  // Clear the whole array on reset. Otherwise write the addressed word when
  // we=1. While rst_n is low, the reset branch wins, so a write in the same
  // cycle is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.we) begin
      r_mem[bus.address] <= bus.write_data;
    end
  end

  assign w_rd_word = r_mem[bus.address];

`ifdef DATA_MEMORY_REG_OUT_EN
  logic [W-1:0] w_rd_q;

  // The output register samples the array before this edge's write lands.
  // A read during a write to the same address therefore returns the old word.
  data_memory_rd_reg #(
    .W (W)
  ) u_rd_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_rd_word),
    .o_q   (w_rd_q)
  );

  assign bus.read_data = w_rd_q;
`else
  // Zero-latency read. A write shows on read_data just after its clock edge.
  assign bus.read_data = w_rd_word;
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory. It covers the
// default build and the DATA_MEMORY_REG_OUT_EN build.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int W     = 32;
  localparam int N     = 5;
  localparam int DEPTH = 1 << N;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_memory_if #(.W(W), .N(N)) bus ();

  data_memory #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // The memory contents as the processor would see them: one plain array.
  logic [W-1:0] model [DEPTH];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  string        tag_q [$];
  event         chk_ev;
  int           n_cmp  = 0;
  int           n_fail = 0;

  // Monitor: each time read_data is presented for checking, pop and compare.
  initial begin
    logic [W-1:0] e;
    string        t;
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: read_data=%h with empty expected queue", bus.read_data);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (bus.read_data !== e) begin
          n_fail++;
          $display("FAIL %s: read_data=%h expected=%h (t=%0t)", t, bus.read_data, e, $time);
        end
      end
    end
  end

  // Queue an expectation for the current read_data and present it to the monitor.
  task automatic expect_rd(input logic [W-1:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    -> chk_ev;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [N-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.we         = 1'b1;
    bus.address    = a;
    bus.write_data = d;
    @(posedge clk);
    if (rst_n) model[a] = d;
    #1;
  endtask

  // Read an address and check it against the model. In the registered build,
  // the word is visible after the next rising edge.
  task automatic do_read(input logic [N-1:0] a, input string tag);
    @(negedge clk);
    bus.we      = 1'b0;
    bus.address = a;
`ifdef DATA_MEMORY_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
    expect_rd(model[a], tag);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    logic [N-1:0] a;

    bus.we         = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    rst_n          = 1'b0;
    model_clear();

    // Reset state.
    #3;
    expect_rd('0, "reset_state");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clear: asynchronous effect mid-cycle, then every word reads 0.
    do_write(5'd7, 32'hDEADBEEF);
    do_read(5'd7, "pre_reset_7");
    @(negedge clk);
    bus.address = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    expect_rd('0, "async_reset_7");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_read(i[N-1:0], "reset_sweep");

    // Full sweep: back-to-back writes, then read everything back.
    for (int i = 0; i < DEPTH; i++) do_write(i[N-1:0], $urandom());
    for (int i = 0; i < DEPTH; i++) do_read(i[N-1:0], "full_sweep");

    // Write disable: we=0 with a changing data bus leaves addr 3 unchanged.
    do_write(5'd3, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.we         = 1'b0;
      bus.address    = 5'd3;
      bus.write_data = 32'hFFFFFFFF;
    end
    do_read(5'd3, "write_disable");

    // Read during write to the same address.
    do_write(5'd10, 32'h0000000A);
    do_read(5'd10, "rdw_setup");
    @(negedge clk);
    bus.we         = 1'b1;
    bus.address    = 5'd10;
    bus.write_data = 32'h0000000B;
`ifdef DATA_MEMORY_REG_OUT_EN
    @(posedge clk);
    #1;
    expect_rd(32'h0000000A, "rdw_first_edge");
    @(negedge clk);
    bus.we = 1'b0;
    @(posedge clk);
    #1;
    expect_rd(32'h0000000B, "rdw_second_edge");
`else
    #1;
    expect_rd(32'h0000000A, "rdw_before_edge");
    @(posedge clk);
    #1;
    expect_rd(32'h0000000B, "rdw_after_edge");
`endif
    model[10] = 32'h0000000B;

    // Boundary addresses, starting from a cleared array.
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd0, 32'h00000001);
    do_write(5'd31, 32'h80000000);
    do_read(5'd0, "boundary_0");
    do_read(5'd31, "boundary_31");
    do_read(5'd1, "boundary_1");
    do_read(5'd30, "boundary_30");

    // A reset in the same cycle as a write: the write is lost.
    do_write(5'd5, 32'h11111111);
    @(negedge clk);
    bus.we         = 1'b1;
    bus.address    = 5'd5;
    bus.write_data = 32'h00000055;
    rst_n          = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    expect_rd('0, "reset_vs_write_during");
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    do_read(5'd5, "reset_vs_write_after");

    // Random mix of writes and reads against the model.
    for (int k = 0; k < 400; k++) begin
      a = N'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        do_write(a, d);
      end else begin
        do_read(a, "random_read");
      end
    end
    for (int i = 0; i < DEPTH; i++) do_read(i[N-1:0], "final_sweep");

    // Every issued expectation must have been consumed by the monitor.
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_data_memory
